// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and widths for the instruction fetch stage.
package instruction_fetch_stage_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned INSTR_W = 32;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      RETRY = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: memory port, redirect/stall controls and IF/ID outputs.
interface instruction_fetch_stage_if;
   import instruction_fetch_stage_pkg::*;

   logic [WORD_W-1:0]  address;
   logic [INSTR_W-1:0] data;
   logic               imem_error;
   logic               stall;
   logic               branch_taken;
   logic [WORD_W-1:0]  branch_target;
   logic               jump;
   logic [WORD_W-1:0]  jump_target;
   logic [INSTR_W-1:0] if_id_instr;
   logic [WORD_W-1:0]  if_id_pc4;
   logic               if_id_valid;
   logic               fetch_fault;

   modport master (
      output address, if_id_instr, if_id_pc4, if_id_valid, fetch_fault,
      input  data, imem_error, stall, branch_taken, branch_target, jump, jump_target
   );

   modport slave (
      input  address, if_id_instr, if_id_pc4, if_id_valid, fetch_fault,
      output data, imem_error, stall, branch_taken, branch_target, jump, jump_target
   );

endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
module if_id_register
   import instruction_fetch_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               bubble,
   input  logic [INSTR_W-1:0] fetch_instr,
   input  logic [WORD_W-1:0]  fetch_pc4,
   output logic [INSTR_W-1:0] instr,
   output logic [WORD_W-1:0]  pc4,
   output logic               valid
);

   // A bubble only clears valid; the stale word and PC+4 are left in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr <= '0;
         pc4   <= '0;
         valid <= 1'b0;
      end else if (load) begin
         instr <= fetch_instr;
         pc4   <= fetch_pc4;
         valid <= 1'b1;
      end else if (bubble) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC, miss-retry/fault FSM and IF/ID register.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned       IMEM_BYTES = 64,
   parameter int unsigned       MISS_RETRY = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   instruction_fetch_stage_if.master  bus
);

   fetch_state_t      state, next_state;
   logic [WORD_W-1:0] pc, next_pc, pc_plus4;
   logic [3:0]        cnt, next_cnt;
   logic              pc_legal;
   logic              ifid_load, ifid_bubble;
   logic [INSTR_W-1:0] ifid_instr;
   logic [WORD_W-1:0]  ifid_pc4;
   logic               ifid_valid;

   assign pc_plus4 = pc + 32'd4;
   assign pc_legal = (pc[1:0] == 2'b00) && (pc <= WORD_W'(IMEM_BYTES - 4));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
         pc    <= RESET_PC;
         cnt   <= '0;
      end else begin
         state <= next_state;
         pc    <= next_pc;
         cnt   <= next_cnt;
      end
   end

   always_comb begin
      next_state  = state;
      next_pc     = pc;
      next_cnt    = cnt;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      if (bus.jump) begin
         next_pc     = bus.jump_target;
         next_state  = FETCH;
         next_cnt    = '0;
         ifid_bubble = 1'b1;
      end else if (bus.branch_taken) begin
         next_pc     = bus.branch_target;
         next_state  = FETCH;
         next_cnt    = '0;
         ifid_bubble = 1'b1;
      end else if (!bus.stall) begin
         unique case (state)
            FETCH: begin
               // An illegal PC faults even when the memory also reports a miss.
               if (!pc_legal) begin
                  next_state  = FAULT;
                  ifid_bubble = 1'b1;
               end else if (bus.imem_error) begin
                  next_state  = RETRY;
                  next_cnt    = 4'(MISS_RETRY);
                  ifid_bubble = 1'b1;
               end else begin
                  ifid_load = 1'b1;
                  next_pc   = pc_plus4;
               end
            end
            RETRY: begin
               ifid_bubble = 1'b1;
               next_cnt    = cnt - 4'd1;
               if (cnt <= 4'd1) begin
                  next_cnt   = '0;
                  next_state = FETCH;
               end
            end
            FAULT: begin
               ifid_bubble = 1'b1;
            end
            default: begin
               next_state  = FETCH;
               ifid_bubble = 1'b1;
            end
         endcase
      end
   end

   if_id_register u_if_id (
      .clk         (clk),
      .rst         (rst),
      .load        (ifid_load),
      .bubble      (ifid_bubble),
      .fetch_instr (bus.data),
      .fetch_pc4   (pc_plus4),
      .instr       (ifid_instr),
      .pc4         (ifid_pc4),
      .valid       (ifid_valid)
   );

   assign bus.address     = pc;
   assign bus.if_id_instr = ifid_instr;
   assign bus.if_id_pc4   = ifid_pc4;
   assign bus.if_id_valid = ifid_valid;
   assign bus.fetch_fault = (state == FAULT);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a 16-word memory model.
module tb_instruction_fetch_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   instruction_fetch_stage_if bus ();

   instruction_fetch_stage #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_BYTES (64),
      .MISS_RETRY (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Word at index i is (i+1)*0x11111111, truncated to 32 bits.
   function automatic logic [31:0] word_at(logic [31:0] a);
      logic [31:0] idx;
      idx = {28'b0, a[5:2]} + 32'd1;
      return idx * 32'h1111_1111;
   endfunction

   assign bus.data = word_at(bus.address);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(string name, logic [31:0] addr, logic [31:0] instr,
                          logic [31:0] pc4, logic valid, logic fault);
      checks++;
      if (bus.address !== addr || bus.if_id_instr !== instr || bus.if_id_pc4 !== pc4 ||
          bus.if_id_valid !== valid || bus.fetch_fault !== fault) begin
         errors++;
         $display("FAIL %s: addr=%h instr=%h pc4=%h valid=%b fault=%b, required addr=%h instr=%h pc4=%h valid=%b fault=%b",
                  name, bus.address, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid,
                  bus.fetch_fault, addr, instr, pc4, valid, fault);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.imem_error = 1'b0; bus.stall = 1'b0;
      bus.jump = 1'b0; bus.jump_target = '0;
      bus.branch_taken = 1'b0; bus.branch_target = '0;
      #12;
      chk_out("reset_state", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_words [4];
      exp_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.address !== 32'(4 * i)) begin
            errors++;
            $display("FAIL seq_addr%0d: got %h required %h", i, bus.address, 32'(4 * i));
         end
         tick();
         chk_out("seq_ifid", 32'(4 * (i + 1)), exp_words[i], 32'(4 * (i + 1)), 1'b1, 1'b0);
      end
   endtask

   task automatic test_stall();
      bus.jump = 1'b1; bus.jump_target = 32'h4;
      tick();
      bus.jump = 1'b0;
      chk_out("stall_setup_jump", 32'h4, 32'h44444444, 32'h10, 1'b0, 1'b0);
      tick();
      chk_out("stall_setup_fetch", 32'h8, 32'h22222222, 32'h8, 1'b1, 1'b0);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("stall_hold", 32'h8, 32'h22222222, 32'h8, 1'b1, 1'b0);
      end
      bus.stall = 1'b0;
      tick();
      chk_out("stall_resume", 32'hC, 32'h33333333, 32'hC, 1'b1, 1'b0);
   endtask

   task automatic test_miss_retry();
      bus.imem_error = 1'b1;
      tick();
      chk_out("miss_enter", 32'hC, 32'h33333333, 32'hC, 1'b0, 1'b0);
      tick();
      chk_out("miss_retry1", 32'hC, 32'h33333333, 32'hC, 1'b0, 1'b0);
      tick();
      chk_out("miss_retry2", 32'hC, 32'h33333333, 32'hC, 1'b0, 1'b0);
      bus.imem_error = 1'b0;
      tick();
      chk_out("miss_refetch", 32'h10, 32'h44444444, 32'h10, 1'b1, 1'b0);
   endtask

   task automatic test_redirect_priority();
      bus.stall = 1'b1;
      bus.jump = 1'b1; bus.jump_target = 32'h20;
      bus.branch_taken = 1'b1; bus.branch_target = 32'h10;
      #1;
      checks++;
      if (bus.address !== 32'h10) begin
         errors++;
         $display("FAIL redirect_not_comb: got %h required %h", bus.address, 32'h10);
      end
      tick();
      chk_out("jump_wins", 32'h20, 32'h44444444, 32'h10, 1'b0, 1'b0);
      bus.jump = 1'b0;
      tick();
      chk_out("branch_under_stall", 32'h10, 32'h44444444, 32'h10, 1'b0, 1'b0);
      bus.branch_taken = 1'b0;
      bus.stall = 1'b0;
   endtask

   task automatic test_fault();
      bus.jump = 1'b1; bus.jump_target = 32'h3C;
      tick();
      bus.jump = 1'b0;
      chk_out("fault_jump60", 32'h3C, 32'h44444444, 32'h10, 1'b0, 1'b0);
      tick();
      chk_out("fault_last_word", 32'h40, 32'h11111110, 32'h40, 1'b1, 1'b0);
      tick();
      chk_out("fault_enter", 32'h40, 32'h11111110, 32'h40, 1'b0, 1'b1);
      tick();
      chk_out("fault_hold", 32'h40, 32'h11111110, 32'h40, 1'b0, 1'b1);
      bus.branch_taken = 1'b1; bus.branch_target = 32'h0;
      tick();
      bus.branch_taken = 1'b0;
      chk_out("fault_exit", 32'h0, 32'h11111110, 32'h40, 1'b0, 1'b0);
      bus.jump = 1'b1; bus.jump_target = 32'h2;
      tick();
      bus.jump = 1'b0;
      bus.imem_error = 1'b1;
      chk_out("misalign_jump", 32'h2, 32'h11111110, 32'h40, 1'b0, 1'b0);
      tick();
      chk_out("misalign_over_miss", 32'h2, 32'h11111110, 32'h40, 1'b0, 1'b1);
      bus.imem_error = 1'b0;
      bus.jump = 1'b1; bus.jump_target = 32'h0;
      tick();
      bus.jump = 1'b0;
      chk_out("misalign_exit", 32'h0, 32'h11111110, 32'h40, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      tick();
      chk_out("ar_fetch0", 32'h4, 32'h11111111, 32'h4, 1'b1, 1'b0);
      bus.imem_error = 1'b1;
      tick();
      chk_out("ar_in_retry", 32'h4, 32'h11111111, 32'h4, 1'b0, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      chk_out("ar_immediate", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      rst = 1'b0;
      bus.imem_error = 1'b0;
      tick();
      chk_out("ar_first_fetch", 32'h4, 32'h11111111, 32'h4, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_miss_retry();
      test_redirect_priority();
      test_fault();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
